// File: rtl/aes_pipe_arbiter.sv
// Round-robin share of one pipelined AES cipher between NREQ requesters; responses carry the requester ID.
// Latency: block accepted in cycle T -> rsp_valid earliest in T+Nr+2 (Nr+1 cipher stages + registered FIFO).
// Backpressure: credit (FIFO + in-flight) stops grants at DEPTH; rsp valid/ready; flush drains for rekey.
// Optional: define AES_ARB_STATS_EN for per-requester grant counters (stat_cnt, stat_clr).
module aes_pipe_arbiter #(
    parameter int NREQ  = 4,
    parameter int Nk    = 4,
    parameter int Nr    = Nk + 6,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][127:0]    req_pt,
    output logic                      c_load,
    output logic [127:0]              c_pt,
    input  logic [127:0]              c_ct,
    input  logic                      c_valid,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [127:0]              rsp_ct,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    input  logic                      flush,
    output logic                      busy,
    output logic                      flush_done
`ifdef AES_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NREQ-1:0][31:0]     stat_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, DRAIN} state_t;

    typedef struct packed {
        logic [127:0]   ct;
        logic [IDW-1:0] id;
    } rsp_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           found;
    logic           issue_ok;
    logic           grant;
    logic           deq;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;

    logic [Nr:0]    tag_v;
    logic [IDW-1:0] tag_id [Nr+1];

    rsp_t           fifo_mem [DEPTH];
    rsp_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  fcnt;
    logic           fifo_full;
    logic           do_wr;

    // Flush blocks grants in the very cycle it is raised, not one cycle later.
    assign issue_ok = (state == RUN) && !flush && (cnt < CW'(DEPTH));

    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant = found && issue_ok;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    assign c_load  = grant;
    assign c_pt    = grant ? req_pt[winner] : '0;
    assign deq     = rsp_valid && rsp_ready;
    assign cnt_nxt = cnt + CW'(grant) - CW'(deq);
    assign busy    = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cnt        <= '0;
            rr_ptr     <= IDW'(NREQ - 1);
            flush_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            flush_done <= 1'b0;
            if (grant) rr_ptr <= winner;
            case (state)
                RUN:   if (flush) state <= DRAIN;
                DRAIN: if (cnt_nxt == '0) begin
                    state      <= RUN;
                    flush_done <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Shadow of the cipher pipeline: stage Nr lines up with c_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k <= Nr; k++) tag_id[k] <= '0;
        end else begin
            tag_v     <= {tag_v[Nr-1:0], grant};
            tag_id[0] <= winner;
            for (int k = 1; k <= Nr; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    // Output FIFO: credit guarantees room for every c_valid.
    assign fifo_full = (fcnt == CW'(DEPTH));
    assign rsp_valid = (fcnt != '0);
    assign head      = fifo_mem[rd_ptr];
    assign rsp_ct    = head.ct;
    assign rsp_id    = head.id;
    assign do_wr     = c_valid && (!fifo_full || deq);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (deq)   rd_ptr <= ptr_inc(rd_ptr);
            if (do_wr && !deq)      fcnt <= fcnt + 1'b1;
            else if (!do_wr && deq) fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) fifo_mem[wr_ptr] <= '{ct: c_ct, id: tag_id[Nr]};
    end

`ifdef AES_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt <= '0;
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (stat_clr)
                    stat_cnt[r] <= (grant && winner == IDW'(r)) ? 32'd1 : 32'd0;
                else if (grant && winner == IDW'(r) && stat_cnt[r] != 32'hFFFF_FFFF)
                    stat_cnt[r] <= stat_cnt[r] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// Bench for aes_pipe_arbiter: stand-in fixed-latency cipher, per-requester drivers, scoreboard of accepted blocks.
module tb_aes_pipe_arbiter;
    localparam int NREQ  = 4;
    localparam int NK    = 4;
    localparam int NR    = NK + 6;
    localparam int DEPTH = 16;
    localparam int IDW   = $clog2(NREQ);
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][127:0] req_pt;
    logic                   c_load;
    logic [127:0]           c_pt;
    logic [127:0]           c_ct;
    logic                   c_valid;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_ct;
    logic [IDW-1:0]         rsp_id;
    logic                   flush;
    logic                   busy;
    logic                   flush_done;
`ifdef AES_ARB_STATS_EN
    logic                   stat_clr;
    logic [NREQ-1:0][31:0]  stat_cnt;
`endif

    aes_pipe_arbiter #(.NREQ(NREQ), .Nk(NK), .Nr(NR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pt(req_pt),
        .c_load(c_load), .c_pt(c_pt), .c_ct(c_ct), .c_valid(c_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct), .rsp_id(rsp_id),
        .flush(flush), .busy(busy), .flush_done(flush_done)
`ifdef AES_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ct;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   glog_id[$];
    int   glog_cyc[$];
    int   rlog_cyc[$];
    int   acc_cnt[NREQ];
    int   target[NREQ];
    int   fips_k = -1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   gcnt = 0;
    int   fd_cnt = 0;
    int   fd_cyc = 0;
    int   fd_grants = 0;
    int   fd_gap = 0;
    int   last_deq_cyc = 0;
    int   max_out = 0;
    logic [127:0] last_ct;
    int   last_id = 0;
    logic prev_vld = 1'b0;
    logic prev_rdy = 1'b0;
    logic [127:0] prev_ct;
    logic [IDW-1:0] prev_id;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in cipher (key 000102..0f): known FIPS-197 answer for the test vector, keyed scramble otherwise.
    function automatic logic [127:0] cipher_model(input logic [127:0] pt);
        if (pt == FIPS_PT) return FIPS_CT;
        return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    logic [NR:0]  cv;
    logic [127:0] cd [NR+1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv <= '0;
        end else begin
            cv    <= {cv[NR-1:0], c_load};
            cd[0] <= cipher_model(c_pt);
            for (int k = 1; k <= NR; k++) cd[k] <= cd[k-1];
        end
    end
    assign c_valid = cv[NR];
    assign c_ct    = cd[NR];

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold valid until their target count of blocks has been accepted.
    initial begin
        req_valid = '0;
        req_pt    = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                req_valid[r] = acc_cnt[r] < target[r];
                req_pt[r]    = (r == 2 && acc_cnt[r] == fips_k) ? FIPS_PT
                             : {32'(r), 32'(acc_cnt[r]), 64'h0123_4567_89ab_cdef};
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_vld = 1'b0;
        end else begin
            chk("busy", busy, sb.size() != 0);
            chk("tag_align", dut.tag_v[NR], c_valid);
            chk("rdy_onehot", $onehot0(req_ready), 1);
            chk("rdy_without_vld", |(req_ready & ~req_valid), 0);
            chk("c_load", c_load, |req_ready);
            if (flush_done) begin
                fd_cnt++;
                fd_cyc    = cyc;
                fd_grants = gcnt;
                fd_gap    = cyc - last_deq_cyc;
            end
            if (prev_vld && !prev_rdy) begin
                chk("rsp_hold_vld", rsp_valid, 1);
                chk("rsp_hold_ct", rsp_ct, prev_ct);
                chk("rsp_hold_id", rsp_id, prev_id);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_ct", rsp_ct, e.ct);
                    chk("rsp_id", rsp_id, e.id);
                end
                last_ct      = rsp_ct;
                last_id      = int'(rsp_id);
                last_deq_cyc = cyc;
                rlog_cyc.push_back(cyc);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (req_ready[r]) begin
                    chk("c_pt", c_pt, req_pt[r]);
                    sb.push_back('{cipher_model(req_pt[r]), r});
                    acc_cnt[r]++;
                    gcnt++;
                    glog_id.push_back(r);
                    glog_cyc.push_back(cyc);
                end
            end
            if (sb.size() > max_out) max_out = sb.size();
            prev_vld = rsp_valid;
            prev_rdy = rsp_ready;
            prev_ct  = rsp_ct;
            prev_id  = rsp_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int i = 0;
        while (gcnt < n && i < budget) begin tick(); i++; end
        chk("grant_wait", gcnt >= n, 1);
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int i = 0;
        while (rlog_cyc.size() < n && i < budget) begin tick(); i++; end
        chk("rsp_wait", rlog_cyc.size() >= n, 1);
    endtask

    task automatic wait_empty(input int budget);
        int i = 0;
        while ((sb.size() != 0 || rsp_valid || busy) && i < budget) begin tick(); i++; end
        chk("drain_wait", sb.size() == 0 && !rsp_valid && !busy, 1);
    endtask

    task automatic stop_all();
        for (int r = 0; r < NREQ; r++) target[r] = acc_cnt[r];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g0, r0, f0, fc, vcount;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
`ifdef AES_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        for (int r = 0; r < NREQ; r++) begin acc_cnt[r] = 0; target[r] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_c_load", c_load, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // All requesters continuously valid: grants 0,1,2,3,... back to back, responses without bubbles.
        for (int r = 0; r < NREQ; r++) target[r] = 4;
        wait_grants(16, 100);
        wait_empty(100);
        for (int i = 0; i < 16; i++) begin
            chk("rr_order", glog_id[i], i % NREQ);
            chk("rr_no_gap", glog_cyc[i] - glog_cyc[0], i);
            chk("rsp_no_gap", rlog_cyc[i] - rlog_cyc[0], i);
        end
        chk("first_latency", rlog_cyc[0] - glog_cyc[0], NR + 2);

        // FIPS-197 vector on requester 2.
        g0 = gcnt;
        r0 = rlog_cyc.size();
        fips_k = acc_cnt[2];
        target[2] = acc_cnt[2] + 1;
        wait_grants(g0 + 1, 50);
        wait_rsps(r0 + 1, 50);
        chk("fips_latency", rlog_cyc[r0] - glog_cyc[g0], NR + 2);
        chk("fips_grant_id", glog_id[g0], 2);
        chk("fips_ct", last_ct, FIPS_CT);
        chk("fips_id", last_id, 2);
        wait_empty(50);

        // Sink stalled: credit admits exactly DEPTH blocks, then one more per dequeue.
        g0 = gcnt;
        rsp_ready = 1'b0;
        for (int r = 0; r < NREQ; r++) target[r] = acc_cnt[r] + 40;
        repeat (40) tick();
        chk("bp_grants", gcnt - g0, DEPTH);
        chk("bp_rdy_low", req_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        repeat (20) tick();
        chk("bp_one_more", gcnt - g0, DEPTH + 1);

        // Alternating then random sink readiness while the FIFO sits at full and near empty.
        for (int i = 0; i < 200; i++) begin
            rsp_ready = (i < 100) ? 1'(i % 2) : 1'($urandom_range(0, 1));
            tick();
        end
        stop_all();
        rsp_ready = 1'b1;
        wait_empty(300);
        chk("max_outstanding", max_out, DEPTH);

        // Flush with 5 blocks in flight; a second flush during drain must not add a pulse.
        g0 = gcnt;
        f0 = fd_cnt;
        for (int r = 0; r < NREQ; r++) target[r] = acc_cnt[r] + 50;
        begin
            int i = 0;
            while (gcnt - g0 < 5 && i < 50) begin tick(); i++; end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        begin
            int i = 0;
            while (fd_cnt == f0 && i < 60) begin tick(); i++; end
        end
        stop_all();
        chk("flush_seen", fd_cnt > f0, 1);
        chk("flush_grants", fd_grants - g0, 5);
        chk("flush_after_last_deq", fd_gap, 1);
        repeat (30) tick();
        chk("flush_pulses", fd_cnt - f0, 1);
        wait_empty(100);

        // Flush with nothing outstanding: done two cycles after the flush cycle.
        f0 = fd_cnt;
        flush = 1'b1;
        fc = cyc;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        chk("idle_flush_pulses", fd_cnt - f0, 1);
        chk("idle_flush_delay", fd_cyc - fc, 2);

        // Reset with 8 blocks in flight.
        g0 = gcnt;
        for (int r = 0; r < NREQ; r++) target[r] = acc_cnt[r] + 50;
        wait_grants(g0 + 8, 30);
        stop_all();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        chk("post_rst_rsp_valid", vcount, 0);
        r0 = rlog_cyc.size();
        tick();
        target[1] = acc_cnt[1] + 1;
        wait_rsps(r0 + 1, 40);
        chk("post_rst_id", last_id, 1);
        wait_empty(40);
`ifdef AES_ARB_STATS_EN
        chk("stat_req1", stat_cnt[1], 1);
        chk("stat_req0", stat_cnt[0], 0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        tick();
        chk("stat_clr", stat_cnt[1], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
